// File: rtl/svm_pkg.sv
// Shared sizes and state encoding for the SVM coefficient loader.
package svm_pkg;

  localparam int COEF_W = 20;              // default coefficient width (4 int + 16 frac)
  localparam int N_COEF = 105;             // coefficients per RAM line (15x7 cell block)
  localparam int N_WORD = 36;              // RAM lines
  localparam int ADDR_W = 6;               // RAM address width
  localparam int RAM_DW = COEF_W * N_COEF; // RAM line width
  localparam int CNT_W  = $clog2(N_COEF);  // pack slot counter width

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    BIAS,
    LOAD,
    VERIFY,
    DRAIN,
    CHECK
  } state_e;

endpackage

// File: rtl/svm_coef_loader_coef_packer.sv
// Slot-indexed pack register: each accepted coefficient lands in the slot
// selected by the running count, first coefficient in the LSBs.
module coef_packer
  import svm_pkg::*;
#(
  parameter int CW = COEF_W,
  parameter int NC = N_COEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [CW-1:0]      coef_i,
  output logic [CW*NC-1:0]   pack_nxt_o,
  output logic               last_o
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW*NC-1:0] pack_q, pack_d;

  // Next slot contents and count; the count wraps after the last slot.
  always_comb begin
    pack_d = pack_q;
    cnt_d  = cnt_q;
    last_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      pack_d[int'(cnt_q)*CW +: CW] = coef_i;
      if (cnt_q == LAST_SLOT) begin
        cnt_d  = '0;
        last_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot counter is control state and is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Pack data needs no reset; every slot is overwritten before use.
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
  end

  // The line is forwarded as it will look after this cycle's write, so the
  // completing coefficient is included when the line is handed off.
  assign pack_nxt_o = pack_d;

endmodule

// File: rtl/svm_coef_loader.sv
// Configuration controller: packs the serial coefficient stream into RAM
// lines, loads the bias, optionally reads the RAM back and XOR-checks it,
// and gates the core ready input on a successful configuration.
module svm_coef_loader
  import svm_pkg::*;
#(
  parameter  int FEA_I = 4,
  parameter  int FEA_F = 16,
  localparam int CW    = FEA_I + FEA_F,
  localparam int DW    = CW * N_COEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CW-1:0]     s_coef,
  output logic [ADDR_W-1:0] addr_a,
  output logic              write_en,
  output logic [DW-1:0]     i_data_a,
  input  logic [DW-1:0]     o_data_a,
  output logic [CW-1:0]     bias,
  output logic              b_load,
  output logic              core_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORD - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              verify_q, verify_d;
  logic              rd_vld_q, rd_vld_d;
  logic              we_q, we_d;
  logic              bload_q, bload_d;
  logic              cr_q, cr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CW-1:0]     bias_q, bias_d;
  logic [DW-1:0]     idata_q, idata_d;
  logic [DW-1:0]     acc_q, acc_d;

  logic              accept;
  logic              pk_wr;
  logic              pk_last;
  logic [DW-1:0]     pack_nxt;

  assign accept  = (state_q == IDLE) && start;
  assign pk_wr   = (state_q == FILL) && s_valid;
  assign s_ready = (state_q == FILL) || (state_q == BIAS);

  coef_packer #(
    .CW (CW),
    .NC (N_COEF)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .wr_i       (pk_wr),
    .coef_i     (s_coef),
    .pack_nxt_o (pack_nxt),
    .last_o     (pk_last)
  );

  // Next-state, counters, accumulator and registered output decode.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    addr_d   = addr_q;
    verify_d = verify_q;
    bias_d   = bias_q;
    idata_d  = idata_q;
    cr_d     = cr_q;
    err_d    = err_q;
    acc_d    = acc_q;
    rd_vld_d = (state_q == VERIFY);

    // Read data returns one cycle after each read issue.
    if (rd_vld_q) acc_d = acc_q ^ o_data_a;

    case (state_q)
      IDLE: begin
        if (start) begin
          verify_d = verify_en;
          err_d    = 1'b0;
          cr_d     = 1'b0;
          word_d   = '0;
          acc_d    = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (pk_last) begin
          addr_d  = word_q;
          idata_d = pack_nxt;
          state_d = WRITE;
        end
      end
      WRITE: begin
        acc_d = acc_q ^ idata_q;
        if (word_q == LAST_WORD) begin
          state_d = BIAS;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = FILL;
        end
      end
      BIAS: begin
        if (s_valid) begin
          bias_d  = s_coef;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (verify_q) begin
          addr_d  = '0;
          state_d = VERIFY;
        end else begin
          state_d = CHECK;
        end
      end
      VERIFY: begin
        if (addr_q == LAST_WORD) state_d = DRAIN;
        else                     addr_d  = addr_q + 1'b1;
      end
      DRAIN:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Written and read-back images cancel in the accumulator when they agree.
    if (state_d == CHECK) begin
      err_d = verify_q && (acc_d != '0);
      cr_d  = !err_d;
    end

    we_d    = (state_d == WRITE);
    bload_d = (state_d == LOAD);
    done_d  = (state_d == CHECK);
    busy_d  = (state_d != IDLE) && (state_d != CHECK);
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      addr_q   <= '0;
      verify_q <= 1'b0;
      rd_vld_q <= 1'b0;
      we_q     <= 1'b0;
      bload_q  <= 1'b0;
      cr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bias_q   <= '0;
      idata_q  <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      verify_q <= verify_d;
      rd_vld_q <= rd_vld_d;
      we_q     <= we_d;
      bload_q  <= bload_d;
      cr_q     <= cr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bias_q   <= bias_d;
      idata_q  <= idata_d;
    end
  end

  // Check accumulator is cleared on every accepted start, not by reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign addr_a     = addr_q;
  assign write_en   = we_q;
  assign i_data_a   = idata_q;
  assign bias       = bias_q;
  assign b_load     = bload_q;
  assign core_ready = cr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_svm_coef_loader.sv
// Bench for svm_coef_loader: table of load scenarios driven with random
// stream duty and coefficients, checked against an array-based RAM image,
// plus hand-written reset and restart sequences.
module tb_svm_coef_loader;

  localparam int CW = 20;
  localparam int NC = 105;
  localparam int NW = 36;
  localparam int DW = CW * NC;
  localparam int NT = NW * NC;   // 3780 weights, bias follows

  logic          clk = 1'b0;
  logic          rst, start, verify_en, s_valid;
  logic          s_ready;
  logic [CW-1:0] s_coef;
  logic [5:0]    addr_a;
  logic          write_en;
  logic [DW-1:0] i_data_a, o_data_a;
  logic [CW-1:0] bias;
  logic          b_load, core_ready, busy, done, error;

  always #5 clk = ~clk;

  svm_coef_loader #(.FEA_I(4), .FEA_F(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .verify_en  (verify_en),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_coef     (s_coef),
    .addr_a     (addr_a),
    .write_en   (write_en),
    .i_data_a   (i_data_a),
    .o_data_a   (o_data_a),
    .bias       (bias),
    .b_load     (b_load),
    .core_ready (core_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // RAM port A model, 1-cycle read latency, optional bit-0 fault on word 7.
  logic [DW-1:0] ram [NW];
  bit            fault = 1'b0;
  always @(posedge clk) begin
    if (write_en && int'(addr_a) < NW) ram[addr_a] <= i_data_a;
    if (int'(addr_a) < NW)
      o_data_a <= ram[addr_a] ^ ((fault && addr_a == 6'd7) ? DW'(1) : DW'(0));
    else
      o_data_a <= '0;
  end

  typedef struct {
    bit            verify;
    bit            fault;
    bit            rnd_coef;
    int            duty;
    bit            mid_start;
    logic [CW-1:0] bias;
    bit            exp_err;
    bit            exp_cr;
    int            exp_lat;
  } vec_t;

  vec_t tbl [6];

  int vec_n  = 0;
  int miss_n = 0;

  // observation log, written only by the stimulus process
  int            cyc = 0;
  int            bload_n, bload_cyc, done_n, done_cyc, ws_viol;
  logic [CW-1:0] bias_seen;
  logic          done_err, done_cr;
  int            wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            rd_addr [$];
  bit            mon_verify;
  bit            hs_prev;
  logic [CW-1:0] coefs [NT+1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    cyc++;
    if (write_en) begin
      wr_addr.push_back(int'(addr_a));
      wr_data.push_back(i_data_a);
      if (s_ready) ws_viol++;
    end
    if (b_load) begin
      bload_n++;
      bload_cyc = cyc;
      bias_seen = bias;
    end
    if (mon_verify && bload_n > 0 && cyc - bload_cyc >= 1 && cyc - bload_cyc <= NW)
      rd_addr.push_back(int'(addr_a));
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_err = error;
      done_cr  = core_ready;
    end
  endtask

  task automatic step();
    hs_prev = s_valid && s_ready;
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    bload_n = 0; bload_cyc = 0; done_n = 0; done_cyc = 0; ws_viol = 0;
  endtask

  task automatic start_load(input bit v, input int row);
    start = 1'b1; verify_en = v;
    step();
    start = 1'b0; verify_en = 1'b0;
    chk($sformatf("row%0d busy_after_start", row), 64'(busy), 64'd1);
    chk($sformatf("row%0d core_ready_after_start", row), 64'(core_ready), 64'd0);
    chk($sformatf("row%0d error_after_start", row), 64'(error), 64'd0);
  endtask

  task automatic run_row(input vec_t r, input int row);
    int i, guard, bad_addr, bad_rd;
    logic [DW-1:0] ew;
    for (int k = 0; k < NT; k++) coefs[k] = r.rnd_coef ? CW'($urandom) : CW'(k);
    coefs[NT] = r.bias;
    fault = r.fault;
    mon_verify = r.verify;
    clear_logs();
    start_load(r.verify, row);

    i = 0; guard = 0;
    while (i <= NT && guard < 20000) begin
      s_valid   = (int'($urandom_range(99)) < r.duty);
      s_coef    = s_valid ? coefs[i] : CW'($urandom);
      start     = r.mid_start && (i == 500);
      verify_en = !r.verify;
      step();
      start = 1'b0;
      if (hs_prev) i++;
      guard++;
    end
    s_valid = 1'b0; verify_en = 1'b0;
    chk($sformatf("row%0d stream_consumed", row), 64'(i), 64'(NT + 1));

    guard = 0;
    while (done_n == 0 && guard < 200) begin
      step();
      guard++;
    end
    chk($sformatf("row%0d done_count", row), 64'(done_n), 64'd1);
    chk($sformatf("row%0d write_count", row), 64'(wr_addr.size()), 64'(NW));

    bad_addr = 0;
    for (int w = 0; w < NW && w < wr_addr.size(); w++) begin
      if (wr_addr[w] != w) bad_addr++;
      for (int s = 0; s < NC; s++) ew[s*CW +: CW] = coefs[w*NC + s];
      vec_n++;
      if (wr_data[w] !== ew) begin
        miss_n++;
        for (int s = 0; s < NC; s++) begin
          if (wr_data[w][s*CW +: CW] !== ew[s*CW +: CW]) begin
            $display("FAIL row%0d word%0d slot%0d: got 0x%0h, expected 0x%0h",
                     row, w, s, wr_data[w][s*CW +: CW], ew[s*CW +: CW]);
            break;
          end
        end
      end
    end
    chk($sformatf("row%0d write_addr_order_errors", row), 64'(bad_addr), 64'd0);
    chk($sformatf("row%0d s_ready_during_write", row), 64'(ws_viol), 64'd0);
    chk($sformatf("row%0d bload_count", row), 64'(bload_n), 64'd1);
    chk($sformatf("row%0d bias", row), 64'(bias_seen), 64'(r.bias));
    chk($sformatf("row%0d done_latency", row), 64'(done_cyc - bload_cyc), 64'(r.exp_lat));
    chk($sformatf("row%0d error_at_done", row), 64'(done_err), 64'(r.exp_err));
    chk($sformatf("row%0d core_ready_at_done", row), 64'(done_cr), 64'(r.exp_cr));

    if (r.verify) begin
      chk($sformatf("row%0d read_count", row), 64'(rd_addr.size()), 64'(NW));
      bad_rd = 0;
      for (int k = 0; k < rd_addr.size(); k++) if (rd_addr[k] != k) bad_rd++;
      chk($sformatf("row%0d read_addr_order_errors", row), 64'(bad_rd), 64'd0);
    end

    step(); step();
    chk($sformatf("row%0d error_sticky", row), 64'(error), 64'(r.exp_err));
    chk($sformatf("row%0d core_ready_hold", row), 64'(core_ready), 64'(r.exp_cr));
    chk($sformatf("row%0d busy_after_done", row), 64'(busy), 64'd0);
    chk($sformatf("row%0d single_done", row), 64'(done_n), 64'd1);
  endtask

  initial begin
    //           vfy flt rnd duty mid bias        err cr lat
    tbl[0] = '{1'b0, 1'b0, 1'b0, 100, 1'b0, 20'h12345, 1'b0, 1'b1, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b0,  50, 1'b1, 20'h12345, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 100, 1'b0, 20'hABCDE, 1'b0, 1'b1, 38};
    tbl[3] = '{1'b1, 1'b1, 1'b1,  70, 1'b0, 20'h00F0F, 1'b1, 1'b0, 38};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 100, 1'b0, 20'hFFFFF, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b0, 1'b1,  50, 1'b1, 20'h80001, 1'b0, 1'b1, 38};

    rst = 1'b1; start = 1'b0; verify_en = 1'b0; s_valid = 1'b0; s_coef = '0;
    mon_verify = 1'b0;
    clear_logs();
    repeat (3) step();
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst write_en", 64'(write_en), 64'd0);
    chk("rst core_ready", 64'(core_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    rst = 1'b0;
    step();
    chk("idle s_ready", 64'(s_ready), 64'd0);
    chk("idle done", 64'(done), 64'd0);

    for (int r = 0; r < 6; r++) run_row(tbl[r], r);

    // reset in the middle of FILL after 50 coefficients
    fault = 1'b0;
    clear_logs();
    start_load(1'b0, 6);
    begin
      int n = 0, g = 0;
      while (n < 50 && g < 200) begin
        s_valid = 1'b1; s_coef = CW'(n);
        step();
        if (hs_prev) n++;
        g++;
      end
      chk("midfill coefs_fed", 64'(n), 64'd50);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("abort s_ready", 64'(s_ready), 64'd0);
    chk("abort write_en", 64'(write_en), 64'd0);
    chk("abort b_load", 64'(b_load), 64'd0);
    chk("abort core_ready", 64'(core_ready), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort error", 64'(error), 64'd0);
    chk("abort addr_a", 64'(addr_a), 64'd0);
    chk("abort i_data_a_any", 64'(|i_data_a), 64'd0);
    chk("abort bias", 64'(bias), 64'd0);
    rst = 1'b0;
    step();
    chk("post_abort core_ready", 64'(core_ready), 64'd0);
    run_row(tbl[2], 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
